// File: rtl/audio_serializer.sv
// audio_serializer
//   Streams a 24-bit mono sample to an I2S DAC. Every 64-BCLK frame carries
//   the same latched word in both the left and right slots, MSB first. Each
//   slot has the usual one-bit I2S delay and ends with seven trailing zeros.
//   A new word is latched only at frame boundaries. A one-clk sample_req
//   pulse tells the sound generator which cycle the word was taken in.
//
// Ports
//   clk        : system clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   enable     : start / keep streaming; only sampled at frame boundaries
//   sample     : 24-bit mixed sample word, latched at frame starts
//   sample_req : one-clk pulse in the cycle the sample is latched
//   bclk       : serial bit clock, period 2*CLK_DIV clks
//   lrck       : word select, 0 = left slot, 1 = right slot
//   sdata      : serial data, changes only with falling bclk
module audio_serializer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] sample,
  output logic        sample_req,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata
);

  typedef enum logic {IDLE, RUN} state_t;

  // Last divider count before bclk toggles; CLK_DIV up to 256 fits in 8 bits.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q,      state_d;
  logic [7:0]  div_cnt_q,    div_cnt_d;
  logic [5:0]  bit_cnt_q,    bit_cnt_d;
  logic [23:0] hold_q,       hold_d;
  logic        bclk_q,       bclk_d;
  logic        lrck_q,       lrck_d;
  logic        sdata_q,      sdata_d;
  logic        sample_req_q, sample_req_d;

  // Bit position after the next falling bclk, and the data bit it carries.
  // Slot position 0 is the I2S delay bit. Positions 1..24 carry the word
  // MSB first. Positions 25..31 are the trailing zeros.
  logic [5:0] bit_next;
  logic [4:0] slot;
  logic [4:0] bit_idx;
  logic       slot_bit;

  always_comb begin
    bit_next = bit_cnt_q + 6'd1;
    slot     = bit_next[4:0];
    bit_idx  = 5'd24 - slot;
    slot_bit = 1'b0;
    if (slot != 5'd0 && slot <= 5'd24) begin
      slot_bit = hold_q[bit_idx];
    end
  end

  // Next-state logic. All outputs are registered, so each decision here
  // appears on the pins one clk later, in step with bclk.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    hold_d       = hold_q;
    bclk_d       = bclk_q;
    lrck_d       = lrck_q;
    sdata_d      = sdata_q;
    sample_req_d = 1'b0;

    case (state_q)
      IDLE: begin
        div_cnt_d = 8'd0;
        bit_cnt_d = 6'd0;
        bclk_d    = 1'b0;
        lrck_d    = 1'b0;
        sdata_d   = 1'b0;
        if (enable) begin
          state_d      = RUN;
          hold_d       = sample;
          sample_req_d = 1'b1;
        end
      end

      RUN: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 8'd0;
          bclk_d    = ~bclk_q;
          // The current bclk is high, so this toggle is a falling event.
          // All serial output changes happen only here.
          if (bclk_q) begin
            bit_cnt_d = bit_next;
            lrck_d    = bit_next[5];
            sdata_d   = slot_bit;
            // Frame boundary. This is the only place enable is evaluated.
            if (bit_next == 6'd0) begin
              if (enable) begin
                hold_d       = sample;
                sample_req_d = 1'b1;
              end else begin
                state_d   = IDLE;
                bclk_d    = 1'b0;
                lrck_d    = 1'b0;
                sdata_d   = 1'b0;
                bit_cnt_d = 6'd0;
                div_cnt_d = 8'd0;
              end
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters, sample hold and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= 8'd0;
      bit_cnt_q    <= 6'd0;
      hold_q       <= 24'd0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      sdata_q      <= 1'b0;
      sample_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      bclk_q       <= bclk_d;
      lrck_q       <= lrck_d;
      sdata_q      <= sdata_d;
      sample_req_q <= sample_req_d;
    end
  end

  assign sample_req = sample_req_q;
  assign bclk       = bclk_q;
  assign lrck       = lrck_q;
  assign sdata      = sdata_q;

endmodule
